// File: rtl/acc_seq_16b.sv
// -----------------------------------------------------------------------------
// acc_seq_16b
// Sequential accumulator placed behind the 16-bit adder datapath. Takes a job
// of LEN operands over a valid/ready input handshake, folds each one into a
// 16-bit running sum (sum + operand + carry-in, carry-in on the first add only),
// and presents the sum, the number of carry-outs and a sticky signed-overflow
// flag over a valid/ready output handshake.
//
// Build option:
//   ACC_SEQ_SAT_EN  - when defined, S saturates to 16'hFFFF in DONE if any add
//                     of the job produced a carry-out. CO_CNT and OVF are
//                     reported unchanged. When undefined, S is the sum
//                     modulo 2^16.
// -----------------------------------------------------------------------------
module acc_seq_16b #(
  parameter int LEN_W = 4,
  parameter int DW    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             CI,
  input  logic [DW-1:0]    D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [DW-1:0]    S,
  output logic [LEN_W-1:0] CO_CNT,
  output logic             OVF,
  output logic             S_VALID,
  input  logic             S_READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_acc;
  logic [LEN_W-1:0] r_rem;
  logic             r_cin;
  logic [LEN_W-1:0] r_co_cnt;
  logic             r_ovf;
  logic [DW-1:0]    r_s;

  // Single add of the datapath: running sum + operand + carry-in.
  logic [DW:0]      w_sum_ext;
  logic [DW-1:0]    w_sum;
  logic             w_c;
  logic             w_ovf_add;
  logic             w_xfer;
  logic             w_last;
  logic [LEN_W-1:0] w_co_next;
  logic [DW-1:0]    w_s_final;

  assign w_sum_ext = {1'b0, r_acc} + {1'b0, D} + {{DW{1'b0}}, r_cin};
  assign w_sum     = w_sum_ext[DW-1:0];
  assign w_c       = w_sum_ext[DW];
  // Signed overflow: both addends share a sign and the result sign differs.
  assign w_ovf_add = (r_acc[DW-1] == D[DW-1]) & (w_sum[DW-1] != r_acc[DW-1]);
  assign w_xfer    = (r_state == ST_ACC) & D_VALID;
  assign w_last    = (r_rem == LEN_W'(1));
  assign w_co_next = r_co_cnt + LEN_W'(w_c);

`ifdef ACC_SEQ_SAT_EN
  // Any carry-out in the job, including the one from this final add, pins S.
  assign w_s_final = (w_c | (r_co_cnt != '0)) ? {DW{1'b1}} : w_sum;
`else
  assign w_s_final = w_sum;
`endif

  // Job control FSM together with the accumulator and the registered results.
  // NOTE: every register here is assigned with <= so all updates see the values
  // from before the edge; blocking assignments would make the order of the
  // statements change the hardware.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cin    <= 1'b0;
      r_co_cnt <= '0;
      r_ovf    <= 1'b0;
      r_s      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_acc    <= '0;
            r_rem    <= LEN;
            r_cin    <= CI;
            r_co_cnt <= '0;
            r_ovf    <= 1'b0;
            if (LEN == '0) begin
              // Empty job: the result is just the carry-in.
              r_s     <= {{(DW-1){1'b0}}, CI};
              r_state <= ST_DONE;
            end else begin
              r_s     <= '0;
              r_state <= ST_ACC;
            end
          end
        end

        ST_ACC: begin
          if (w_xfer) begin
            r_acc    <= w_sum;
            r_cin    <= 1'b0;
            r_co_cnt <= w_co_next;
            r_ovf    <= r_ovf | w_ovf_add;
            r_rem    <= r_rem - LEN_W'(1);
            if (w_last) begin
              r_s     <= w_s_final;
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // START is not looked at here, even in the handshake cycle.
          if (S_READY) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs decode the state register only.
  assign D_READY = (r_state == ST_ACC);
  assign S_VALID = (r_state == ST_DONE);
  assign BUSY    = (r_state != ST_IDLE);
  assign S       = r_s;
  assign CO_CNT  = r_co_cnt;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_acc_seq_16b.sv
// -----------------------------------------------------------------------------
// tb_acc_seq_16b
// Scoreboard bench for acc_seq_16b. A reference model computes the expected
// result of each job when its START is driven; the monitor pops and compares on
// every output handshake. Compile with +define+ACC_SEQ_SAT_EN to check the
// saturating build.
// -----------------------------------------------------------------------------
module tb_acc_seq_16b;

  localparam int LEN_W = 4;
  localparam int DW    = 16;

  typedef struct packed {
    logic [DW-1:0]    s;
    logic [LEN_W-1:0] co;
    logic             ovf;
  } exp_t;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             CI;
  logic [DW-1:0]    D;
  logic             D_VALID;
  logic             D_READY;
  logic [DW-1:0]    S;
  logic [LEN_W-1:0] CO_CNT;
  logic             OVF;
  logic             S_VALID;
  logic             S_READY;
  logic             BUSY;

  int   n_chk;
  int   n_err;
  exp_t sb_q[$];

  acc_seq_16b #(.LEN_W(LEN_W), .DW(DW)) u_dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .LEN     (LEN),
    .CI      (CI),
    .D       (D),
    .D_VALID (D_VALID),
    .D_READY (D_READY),
    .S       (S),
    .CO_CNT  (CO_CNT),
    .OVF     (OVF),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of one job: a plain loop over the operands.
  function automatic exp_t model(input logic ci, input int len, input logic [DW-1:0] ops[16]);
    exp_t        e;
    logic [DW:0] t;
    logic [DW-1:0] acc;
    logic        cin;
    int          co;
    logic        ovf;
    acc = '0;
    cin = ci;
    co  = 0;
    ovf = 1'b0;
    for (int i = 0; i < len; i++) begin
      t = {1'b0, acc} + {1'b0, ops[i]} + {{DW{1'b0}}, cin};
      if ((acc[DW-1] == ops[i][DW-1]) && (t[DW-1] != acc[DW-1])) ovf = 1'b1;
      co  = co + int'(t[DW]);
      acc = t[DW-1:0];
      cin = 1'b0;
    end
    e.s   = (len == 0) ? {{(DW-1){1'b0}}, ci} : acc;
`ifdef ACC_SEQ_SAT_EN
    if (co != 0) e.s = {DW{1'b1}};
`endif
    e.co  = LEN_W'(co);
    e.ovf = ovf;
    return e;
  endfunction

  // Output monitor: every accepted result must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && S_VALID && S_READY) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("S", 32'(S), 32'(e.s));
        check("CO_CNT", 32'(CO_CNT), 32'(e.co));
        check("OVF", 32'(OVF), 32'(e.ovf));
      end
    end
  end

  // Drive one job; returns right after checking S_VALID in the cycle after the last operand.
  task automatic run_job(input logic ci, input int len, input logic [DW-1:0] ops[16], input bit gap);
    bit ok;
    @(posedge CLK); #1;
    START = 1'b1;
    LEN   = LEN_W'(len);
    CI    = ci;
    sb_q.push_back(model(ci, len, ops));
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 0; i < len; i++) begin
      D_VALID = 1'b1;
      D       = ops[i];
      ok      = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge CLK);
        ok = D_READY;
        @(posedge CLK); #1;
      end
      if (!ok) check("d_ready_timeout", 32'd0, 32'd1);
      D_VALID = 1'b0;
      D       = 16'hDEAD;
      if (gap && (i < len - 1)) begin
        @(posedge CLK); #1;
      end
    end
    @(negedge CLK);
    check("s_valid_latency", 32'(S_VALID), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK);
      if (!BUSY) ok = 1'b1;
    end
    check("idle_wait", 32'(ok), 32'd1);
  endtask

  logic [DW-1:0] ops[16];

  task automatic clear_ops();
    for (int i = 0; i < 16; i++) ops[i] = '0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    RST_N   = 1'b0;
    START   = 1'b0;
    LEN     = '0;
    CI      = 1'b0;
    D       = '0;
    D_VALID = 1'b0;
    S_READY = 1'b1;
    clear_ops();

    // Reset state.
    #12;
    check("rst_S", 32'(S), 32'd0);
    check("rst_CO_CNT", 32'(CO_CNT), 32'd0);
    check("rst_OVF", 32'(OVF), 32'd0);
    check("rst_S_VALID", 32'(S_VALID), 32'd0);
    check("rst_D_READY", 32'(D_READY), 32'd0);
    check("rst_BUSY", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset mid-job: accept one operand, then pull reset between edges.
    @(posedge CLK); #1;
    START = 1'b1; LEN = 4'd3; CI = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0; D_VALID = 1'b1; D = 16'h0001;
    @(posedge CLK); #1;
    D_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_S_VALID", 32'(S_VALID), 32'd0);
    check("midrst_BUSY", 32'(BUSY), 32'd0);
    check("midrst_D_READY", 32'(D_READY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_idle_BUSY", 32'(BUSY), 32'd0);
    check("midrst_idle_S", 32'(S), 32'd0);

    // Basic sum with one stall cycle between operands.
    clear_ops();
    ops[0] = 16'h0010; ops[1] = 16'h0020; ops[2] = 16'h0030;
    run_job(1'b1, 3, ops, 1'b1);
    wait_idle();

    // Carry count and wrap.
    clear_ops();
    ops[0] = 16'hFFFF; ops[1] = 16'h0002;
    run_job(1'b0, 2, ops, 1'b0);
    wait_idle();

    // Signed overflow, positive then negative.
    clear_ops();
    ops[0] = 16'h7FFF; ops[1] = 16'h0001;
    run_job(1'b0, 2, ops, 1'b0);
    wait_idle();
    ops[0] = 16'h8000; ops[1] = 16'h8000;
    run_job(1'b0, 2, ops, 1'b0);
    wait_idle();

    // Zero length with four cycles of output backpressure; STARTs are ignored.
    S_READY = 1'b0;
    clear_ops();
    run_job(1'b1, 0, ops, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      START = (i == 1);
      LEN   = 4'd5;
      @(negedge CLK);
      check("bp_S_VALID_held", 32'(S_VALID), 32'd1);
      check("bp_S_held", 32'(S), 32'd1);
    end
    // Handshake completes while START is also high: that START is dropped.
    @(posedge CLK); #1;
    START   = 1'b1;
    S_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("bp_back_idle_BUSY", 32'(BUSY), 32'd0);
    check("bp_back_idle_S_VALID", 32'(S_VALID), 32'd0);
    check("bp_back_idle_D_READY", 32'(D_READY), 32'd0);
    check("bp_S_holds_in_idle", 32'(S), 32'd1);

    // Max length, all ones, carry-in set.
    for (int i = 0; i < 15; i++) ops[i] = 16'hFFFF;
    run_job(1'b1, 15, ops, 1'b0);
    wait_idle();

    // A few random jobs with random stalls.
    for (int j = 0; j < 6; j++) begin
      int l;
      clear_ops();
      l = $urandom_range(1, 15);
      for (int i = 0; i < l; i++) ops[i] = DW'($urandom);
      run_job(1'(($urandom) & 1), l, ops, 1'(j & 1));
      wait_idle();
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
